// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the video timing generator.
//  - Default 640x480@60 timing constants.
//  - timing_t: one axis of a raster (active, front porch, sync, back porch).
//  - total(): full length of an axis.
//  - cnt_width(): counter width for a modulus, never narrower than one bit.
//  - in_window(): half-open range test [lo, lo+width); zero width never matches.
package vga_timing_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } timing_t;

   function automatic int unsigned total(input timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                      input int unsigned width);
      return (v >= lo) && (v < lo + width);
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear.
// Ports:
//  clk    in   system clock
//  rst_n  in   asynchronous active-low reset, count -> 0
//  inc    in   advance by one this clk
//  clr    in   synchronous clear to 0, overrides inc
//  count  out  current value, 0..MOD-1
//  wrap   out  inc && count == MOD-1 (count returns to 0 on this clk)
module mod_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned MOD = 2,
   localparam int unsigned CW = cnt_width(MOD)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(MOD - 1);

   logic [CW-1:0] count_q, count_d;

   assign wrap  = inc && (count_q == LAST);
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (wrap) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator.
// Ports:
//  clk               in   system clock
//  rst_n             in   asynchronous active-low reset
//  en                in   run; 0 freezes prescaler, counters and flags
//  sync_clr          in   synchronous restart to dot 0 / line 0 (overrides en)
//  dot_counter       out  current dot, 0..H_TOTAL-1
//  scanline_counter  out  current line, 0..V_TOTAL-1
//  pix_en            out  one-clk dot strobe
//  active            out  visible-area flag (registered)
//  hsync             out  horizontal sync, HSYNC_POL when asserted (registered)
//  vsync             out  vertical sync, VSYNC_POL when asserted (registered)
//  line_start        out  pix_en && dot == 0
//  frame_start       out  pix_en && dot == 0 && line == 0
module video_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
   parameter int unsigned H_FP      = VGA_H_FP,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BP      = VGA_H_BP,
   parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
   parameter int unsigned V_FP      = VGA_V_FP,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BP      = VGA_V_BP,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter int unsigned PIX_DIV   = 1,
   localparam timing_t     H_TIM    = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP},
   localparam timing_t     V_TIM    = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP},
   localparam int unsigned H_TOTAL  = total(H_TIM),
   localparam int unsigned V_TOTAL  = total(V_TIM),
   localparam int unsigned HW       = cnt_width(H_TOTAL),
   localparam int unsigned VW       = cnt_width(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          sync_clr,
   output logic [HW-1:0] dot_counter,
   output logic [VW-1:0] scanline_counter,
   output logic          pix_en,
   output logic          active,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start
);

   localparam int unsigned PW     = cnt_width(PIX_DIV);
   localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
   localparam int unsigned VS_BEG = V_ACTIVE + V_FP;

   if (H_ACTIVE == 0 || V_ACTIVE == 0 || PIX_DIV == 0) begin : g_bad_param
      $error("video_timing_gen: H_ACTIVE, V_ACTIVE and PIX_DIV must all be >= 1");
   end

   logic [PW-1:0] presc_cnt;
   logic          presc_wrap;
   logic [HW-1:0] dot_cnt, dot_d;
   logic          dot_wrap;
   logic [VW-1:0] line_cnt, line_d;
   logic          line_wrap;
   logic          unused_presc;

   logic active_q, active_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;

   // Only the prescaler's wrap is of interest; its count just sequences it.
   assign unused_presc = ^presc_cnt;

   mod_counter #(
      .MOD (PIX_DIV)
   ) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (en),
      .clr   (sync_clr),
      .count (presc_cnt),
      .wrap  (presc_wrap)
   );

   // Gated by rst_n so the strobe and pulses are quiet while reset is held, even with PIX_DIV=1.
   assign pix_en = presc_wrap && rst_n;

   mod_counter #(
      .MOD (H_TOTAL)
   ) u_dot (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pix_en),
      .clr   (sync_clr),
      .count (dot_cnt),
      .wrap  (dot_wrap)
   );

   mod_counter #(
      .MOD (V_TOTAL)
   ) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (dot_wrap),
      .clr   (sync_clr),
      .count (line_cnt),
      .wrap  (line_wrap)
   );

   // Next-state counter values, so the registered flags describe the counters of the same cycle.
   always_comb begin
      dot_d  = dot_cnt;
      line_d = line_cnt;
      if (sync_clr) begin
         dot_d  = '0;
         line_d = '0;
      end else if (dot_wrap) begin
         dot_d  = '0;
         line_d = line_wrap ? '0 : line_cnt + VW'(1);
      end else if (pix_en) begin
         dot_d = dot_cnt + HW'(1);
      end
   end

   always_comb begin
      active_d = in_window(32'(dot_d), 0, H_ACTIVE) && in_window(32'(line_d), 0, V_ACTIVE);
      hsync_d  = in_window(32'(dot_d), HS_BEG, H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d  = in_window(32'(line_d), VS_BEG, V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         hsync_q  <= ~HSYNC_POL;
         vsync_q  <= ~VSYNC_POL;
      end else begin
         active_q <= active_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
      end
   end

   assign dot_counter      = dot_cnt;
   assign scanline_counter = line_cnt;
   assign active           = active_q;
   assign hsync            = hsync_q;
   assign vsync            = vsync_q;
   assign line_start       = pix_en && (dot_cnt == '0);
   assign frame_start      = pix_en && (dot_cnt == '0) && (line_cnt == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic sync_clr = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // u_def: default 640x480 timing
   logic [9:0] d_dot, d_line;
   logic d_pix, d_act, d_hs, d_vs, d_ls, d_fs;
   // u_zero: no horizontal porches or sync
   logic [9:0] z_dot, z_line;
   logic z_pix, z_act, z_hs, z_vs, z_ls, z_fs;
   // u_div: default timing, PIX_DIV=4
   logic [9:0] p_dot, p_line;
   logic p_pix, p_act, p_hs, p_vs, p_ls, p_fs;
   // u_small: 12x8 raster, PIX_DIV=3, active-high syncs
   logic [3:0] s_dot;
   logic [2:0] s_line;
   logic s_pix, s_act, s_hs, s_vs, s_ls, s_fs;

   video_timing_gen u_def (
      .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
      .dot_counter(d_dot), .scanline_counter(d_line), .pix_en(d_pix), .active(d_act),
      .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
   );

   video_timing_gen #(.H_FP(0), .H_SYNC(0), .H_BP(0)) u_zero (
      .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
      .dot_counter(z_dot), .scanline_counter(z_line), .pix_en(z_pix), .active(z_act),
      .hsync(z_hs), .vsync(z_vs), .line_start(z_ls), .frame_start(z_fs)
   );

   video_timing_gen #(.PIX_DIV(4)) u_div (
      .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
      .dot_counter(p_dot), .scanline_counter(p_line), .pix_en(p_pix), .active(p_act),
      .hsync(p_hs), .vsync(p_vs), .line_start(p_ls), .frame_start(p_fs)
   );

   video_timing_gen #(
      .H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_DIV(3)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
      .dot_counter(s_dot), .scanline_counter(s_line), .pix_en(s_pix), .active(s_act),
      .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
   );

   // Reset held for two clks, released just after a falling edge.
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      en       = 1'b1;
      sync_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      en       = 1'b1;
      sync_clr = 1'b0;
      #1;
      n_checks++;
      if (d_dot !== 10'd0 || d_line !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_def_counters: got %0d/%0d want 0/0", d_dot, d_line);
      end
      n_checks++;
      if ({d_pix, d_act, d_hs, d_vs, d_ls, d_fs} !== 6'b001100) begin
         n_fail++;
         $display("FAIL reset_def_flags: got %b want 001100", {d_pix, d_act, d_hs, d_vs, d_ls, d_fs});
      end
      n_checks++;
      if (s_dot !== 4'd0 || s_line !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_small_counters: got %0d/%0d want 0/0", s_dot, s_line);
      end
      n_checks++;
      if ({s_pix, s_act, s_hs, s_vs, s_ls, s_fs} !== 6'b000000) begin
         n_fail++;
         $display("FAIL reset_small_flags: got %b want 000000", {s_pix, s_act, s_hs, s_vs, s_ls, s_fs});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (d_dot !== 10'd1 || d_act !== 1'b1 || d_hs !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_clk: got dot=%0d active=%b hsync=%b want dot=1 active=1 hsync=1",
                  d_dot, d_act, d_hs);
      end
   endtask

   task automatic test_zero_porch();
      int hs_bad = 0;
      do_reset();
      for (int k = 1; k <= 640; k++) begin
         @(negedge clk);
         #1;
         if (z_hs !== 1'b1) hs_bad++;
         if (k == 638 || k == 639 || k == 640) begin
            n_checks++;
            if (z_dot !== 10'(k % 640) || z_line !== 10'(k / 640)) begin
               n_fail++;
               $display("FAIL zero_porch_count k=%0d: got %0d/%0d want %0d/%0d",
                        k, z_dot, z_line, k % 640, k / 640);
            end
         end
      end
      n_checks++;
      if (hs_bad != 0) begin
         n_fail++;
         $display("FAIL zero_porch_hsync: got %0d asserted samples want 0", hs_bad);
      end
   endtask

   task automatic test_hsync();
      int hs_low = 0;
      int ls_cnt = 0;
      do_reset();
      for (int k = 1; k <= 1600; k++) begin
         int  ed, el;
         logic ea, eh;
         @(negedge clk);
         #1;
         ed = k % 800;
         el = k / 800;
         ea = (ed < 640);
         eh = !(ed >= 656 && ed < 752);
         n_checks++;
         if (d_dot !== 10'(ed) || d_line !== 10'(el)) begin
            n_fail++;
            $display("FAIL hsync_count k=%0d: got %0d/%0d want %0d/%0d", k, d_dot, d_line, ed, el);
         end
         n_checks++;
         if (d_act !== ea || d_hs !== eh) begin
            n_fail++;
            $display("FAIL hsync_flags k=%0d: got active=%b hsync=%b want %b %b",
                     k, d_act, d_hs, ea, eh);
         end
         if (k <= 800 && d_hs === 1'b0) hs_low++;
         if (d_ls === 1'b1) ls_cnt++;
      end
      n_checks++;
      if (hs_low != 96) begin
         n_fail++;
         $display("FAIL hsync_width: got %0d want 96", hs_low);
      end
      n_checks++;
      if (ls_cnt != 2) begin
         n_fail++;
         $display("FAIL line_start_rate: got %0d in 1600 clks want 2", ls_cnt);
      end
   endtask

   // One full frame of the small raster: 12 dots * 8 lines * 3 clks.
   task automatic test_frame();
      int fs_cnt = 0;
      do_reset();
      for (int k = 1; k <= 288; k++) begin
         int  np, ed, el;
         logic ep, ea, eh, ev;
         @(negedge clk);
         #1;
         np = k / 3;
         ed = np % 12;
         el = (np / 12) % 8;
         ep = ((k % 3) == 2);
         ea = (ed < 5) && (el < 4);
         eh = (ed >= 7 && ed < 10);
         ev = (el >= 5 && el < 7);
         n_checks++;
         if (s_dot !== 4'(ed) || s_line !== 3'(el) || s_pix !== ep) begin
            n_fail++;
            $display("FAIL frame_count k=%0d: got %0d/%0d pix=%b want %0d/%0d pix=%b",
                     k, s_dot, s_line, s_pix, ed, el, ep);
         end
         n_checks++;
         if (s_act !== ea || s_hs !== eh || s_vs !== ev) begin
            n_fail++;
            $display("FAIL frame_flags k=%0d: got a/h/v=%b%b%b want %b%b%b",
                     k, s_act, s_hs, s_vs, ea, eh, ev);
         end
         if (s_fs === 1'b1) fs_cnt++;
      end
      n_checks++;
      if (fs_cnt != 1) begin
         n_fail++;
         $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
      end
   endtask

   task automatic test_prescaler();
      do_reset();
      for (int k = 1; k <= 3208; k++) begin
         int  np;
         logic ep;
         @(negedge clk);
         #1;
         np = k / 4;
         ep = ((k % 4) == 3);
         n_checks++;
         if (p_pix !== ep || p_dot !== 10'(np % 800) || p_line !== 10'(np / 800)) begin
            n_fail++;
            $display("FAIL presc k=%0d: got pix=%b %0d/%0d want pix=%b %0d/%0d",
                     k, p_pix, p_dot, p_line, ep, np % 800, np / 800);
         end
      end
   endtask

   task automatic test_freeze();
      do_reset();
      repeat (300) @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++;
         if (d_dot !== 10'd300 || d_line !== 10'd0 ||
             {d_pix, d_act, d_hs, d_vs, d_ls} !== 5'b01110) begin
            n_fail++;
            $display("FAIL freeze_hold i=%0d: got %0d/%0d flags=%b want 300/0 flags=01110",
                     i, d_dot, d_line, {d_pix, d_act, d_hs, d_vs, d_ls});
         end
         @(negedge clk);
      end
      en = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (d_dot !== 10'd301) begin
         n_fail++;
         $display("FAIL freeze_resume: got %0d want 301", d_dot);
      end
      repeat (5799) @(negedge clk);
      #1;
      n_checks++;
      if (d_dot !== 10'd500 || d_line !== 10'd7) begin
         n_fail++;
         $display("FAIL clr_setup: got %0d/%0d want 500/7", d_dot, d_line);
      end
      sync_clr = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0;
      #1;
      n_checks++;
      if (d_dot !== 10'd0 || d_line !== 10'd0 || {d_act, d_hs, d_vs} !== 3'b111 ||
          d_pix !== 1'b1 || d_fs !== 1'b1) begin
         n_fail++;
         $display("FAIL sync_clr: got %0d/%0d a/h/v=%b%b%b pix=%b fs=%b want 0/0 111 1 1",
                  d_dot, d_line, d_act, d_hs, d_vs, d_pix, d_fs);
      end
      @(negedge clk);
      en       = 1'b0;
      sync_clr = 1'b1;
      #1;
      n_checks++;
      if (d_dot !== 10'd1) begin
         n_fail++;
         $display("FAIL clr_frozen_setup: got %0d want 1", d_dot);
      end
      @(negedge clk);
      sync_clr = 1'b0;
      #1;
      n_checks++;
      if (d_dot !== 10'd0 || d_line !== 10'd0 || d_pix !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_frozen: got %0d/%0d pix=%b want 0/0 pix=0", d_dot, d_line, d_pix);
      end
      en = 1'b1;
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (1234) @(negedge clk);
      @(posedge clk);
      #2;
      n_checks++;
      if (d_dot !== 10'd435 || d_line !== 10'd1) begin
         n_fail++;
         $display("FAIL async_setup: got %0d/%0d want 435/1", d_dot, d_line);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (d_dot !== 10'd0 || d_line !== 10'd0 ||
          {d_pix, d_act, d_hs, d_vs, d_ls, d_fs} !== 6'b001100) begin
         n_fail++;
         $display("FAIL async_reset: got %0d/%0d flags=%b want 0/0 flags=001100",
                  d_dot, d_line, {d_pix, d_act, d_hs, d_vs, d_ls, d_fs});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (638) @(negedge clk);
      #1;
      n_checks++;
      if (d_dot !== 10'd638 || d_line !== 10'd0 || d_act !== 1'b1) begin
         n_fail++;
         $display("FAIL async_restart: got %0d/%0d active=%b want 638/0 active=1",
                  d_dot, d_line, d_act);
      end
   endtask

   // Reference: a clear zeroes the run-clk count and the dot-event count; each enabled clk
   // whose run count is 2 mod 3 is a dot event. Position follows from the dot-event count.
   task automatic test_random();
      int  ecount = 0;
      int  npix   = 0;
      bit  fv     = 1'b0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int  ed, el;
         logic ep, el0, ea, eh, ev;
         en       = ($urandom_range(0, 3) != 0);
         sync_clr = ($urandom_range(0, 19) == 0);
         #1;
         ed  = npix % 12;
         el  = (npix / 12) % 8;
         ep  = en && ((ecount % 3) == 2);
         el0 = (el == 0);
         ea  = fv && (ed < 5) && (el < 4);
         eh  = fv && (ed >= 7 && ed < 10);
         ev  = fv && (el >= 5 && el < 7);
         n_checks++;
         if (s_dot !== 4'(ed) || s_line !== 3'(el)) begin
            n_fail++;
            $display("FAIL rand_count c=%0d: got %0d/%0d want %0d/%0d", c, s_dot, s_line, ed, el);
         end
         n_checks++;
         if (s_pix !== ep || s_ls !== (ep && ed == 0) || s_fs !== (ep && ed == 0 && el0)) begin
            n_fail++;
            $display("FAIL rand_pulses c=%0d: got pix/ls/fs=%b%b%b want %b%b%b", c,
                     s_pix, s_ls, s_fs, ep, ep && ed == 0, ep && ed == 0 && el0);
         end
         n_checks++;
         if (s_act !== ea || s_hs !== eh || s_vs !== ev) begin
            n_fail++;
            $display("FAIL rand_flags c=%0d: got a/h/v=%b%b%b want %b%b%b",
                     c, s_act, s_hs, s_vs, ea, eh, ev);
         end
         @(posedge clk);
         if (sync_clr) begin
            ecount = 0;
            npix   = 0;
         end else if (en) begin
            if ((ecount % 3) == 2) npix++;
            ecount++;
         end
         fv = 1'b1;
         @(negedge clk);
      end
      en       = 1'b1;
      sync_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_porch();
      test_hsync();
      test_frame();
      test_prescaler();
      test_freeze();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
